// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between the interconnect (master side: address/control, HREADY mux) and one subordinate.
// HREADY is driven by the interconnect side; HREADYOUT/HRESP/HRDATA come back from the subordinate.
interface ahb_sram_subordinate_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: data phase completes after WAIT_STATES cycles, illegal accesses get a 2-cycle ERROR.
// Stalls the bus via HREADYOUT only; AHB_SUB_WRITE_PROTECT_EN adds a wr_protect input that turns writes into ERRORs.
module ahb_sram_subordinate #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    MEM_DEPTH   = 1024,
  parameter int                    WAIT_STATES = 0
) (
  input  logic HCLK,
  input  logic HRESET,
`ifdef AHB_SUB_WRITE_PROTECT_EN
  input  logic wr_protect,
`endif
  ahb_sram_subordinate_if.slave bus
);
  localparam int                    IDX_W        = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [2:0]            WS           = 3'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                state_q, state_d;
  logic                  dph_vld_q, dph_vld_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic                  wr_q;
  logic [2:0]            size_q;
  logic [1:0]            alo_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  hreadyout, hresp, cap, illegal, done;
  logic [ADDR_WIDTH-1:0] offset;
  logic [3:0]            lanes;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  assign offset    = bus.HADDR - BASE_ADDR;
  assign unused_ok = ^bus.HBURST;

  always_comb begin
    illegal = (offset >= REGION_BYTES) || (bus.HSIZE > 3'b010) ||
              (bus.HSIZE == 3'b001 && bus.HADDR[0]) ||
              (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00);
`ifdef AHB_SUB_WRITE_PROTECT_EN
    illegal = illegal || (bus.HWRITE && wr_protect);
`endif
  end

  // A legal transfer's data phase finishes in the IDLE cycle that follows its wait states.
  assign cap  = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout;
  assign done = (state_q == ST_IDLE) & dph_vld_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      dph_vld_q <= 1'b0;
      wcnt_q    <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      alo_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      dph_vld_q <= dph_vld_d;
      wcnt_q    <= wcnt_d;
      if (cap) begin
        wr_q   <= bus.HWRITE;
        size_q <= bus.HSIZE;
        alo_q  <= bus.HADDR[1:0];
        idx_q  <= offset[IDX_W+1:2];
      end
      if (done && !wr_q) hold_q <= rd_word;
    end
  end

  always_comb begin
    state_d   = state_q;
    dph_vld_d = dph_vld_q;
    wcnt_d    = wcnt_q;
    if (done) dph_vld_d = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (cap && illegal) begin
          state_d = ST_ERR1;
        end else if (cap) begin
          dph_vld_d = 1'b1;
          if (WS != 3'd0) begin
            state_d = ST_WAIT;
            wcnt_d  = WS;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    lanes = 4'b1111;
    case (size_q)
      3'b000:  lanes = 4'b0001 << alo_q;
      3'b001:  lanes = alo_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  // Writes land on the completing edge, so a read captured on that same edge sees the new word.
  always_ff @(posedge HCLK) begin
    if (done && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign rd_word       = mem_q[idx_q];
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = (dph_vld_q && !wr_q) ? rd_word : hold_q;
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: one instance with no wait states, one with two, sharing a pipelined AHB driver.
// Expected responses come from a vector table and from a byte-array model of the SRAM region.
module tb_ahb_sram_subordinate;
  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_model;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wp  = 1'b0;
  always #5 clk = ~clk;

  logic        m_sel, m_wr;
  logic [1:0]  m_trans;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  int          which;
  logic        s_rdy, s_resp;
  logic [31:0] s_rdata;

  ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.HSEL   = m_sel && (which == 0);
  assign bus2.HSEL   = m_sel && (which == 1);
  assign bus0.HADDR  = m_addr;
  assign bus2.HADDR  = m_addr;
  assign bus0.HTRANS = m_trans;
  assign bus2.HTRANS = m_trans;
  assign bus0.HWRITE = m_wr;
  assign bus2.HWRITE = m_wr;
  assign bus0.HSIZE  = m_size;
  assign bus2.HSIZE  = m_size;
  assign bus0.HBURST = 3'b000;
  assign bus2.HBURST = 3'b001;
  assign bus0.HWDATA = m_wdata;
  assign bus2.HWDATA = m_wdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  assign s_rdy   = (which == 1) ? bus2.HREADYOUT : bus0.HREADYOUT;
  assign s_resp  = (which == 1) ? bus2.HRESP     : bus0.HRESP;
  assign s_rdata = (which == 1) ? bus2.HRDATA    : bus0.HRDATA;

  ahb_sram_subordinate #(.BASE_ADDR(BASE), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk),
    .HRESET(rst),
`ifdef AHB_SUB_WRITE_PROTECT_EN
    .wr_protect(wp),
`endif
    .bus(bus0)
  );

  ahb_sram_subordinate #(.BASE_ADDR(BASE), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
    .HCLK(clk),
    .HRESET(rst),
`ifdef AHB_SUB_WRITE_PROTECT_EN
    .wr_protect(wp),
`endif
    .bus(bus2)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem8 [2][4096];
  logic [31:0] last_rd [2];
  op_t         tbl [$];
  op_t         ops [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                             input logic [31:0] off, input logic [31:0] wd,
                             input logic ee, input logic [31:0] er, input logic cm);
    op_t o;
    o.trans = tr; o.wr = wr; o.size = sz; o.addr = BASE + off; o.wdata = wd;
    o.exp_err = ee; o.exp_rdata = er; o.chk_model = cm;
    return o;
  endfunction

  function automatic logic model_err(input op_t o);
    logic [31:0] off;
    off = o.addr - BASE;
    return (off >= 32'h1000) || (o.size > 3'd2) ||
           ((o.addr & ((32'd1 << o.size) - 32'd1)) != 32'd0) || (wp && o.wr);
  endfunction

  task automatic model_wr(input int w, input op_t o);
    int off;
    off = int'(o.addr - BASE);
    for (int j = 0; j < (1 << o.size); j++) begin
      int a;
      a = off + j;
      mem8[w][a] = o.wdata[8*(a%4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_rd(input int w, input logic [31:0] addr);
    int wa;
    wa = int'((addr - BASE) & 32'h0000_0FFC);
    return {mem8[w][wa+3], mem8[w][wa+2], mem8[w][wa+1], mem8[w][wa]};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    r = int'($urandom_range(0, 99));
    o.trans = (r < 10) ? 2'b00 : (r < 18) ? 2'b01 : (r < 60) ? 2'b10 : 2'b11;
    o.wr    = 1'($urandom_range(0, 1));
    r = int'($urandom_range(0, 99));
    o.size  = (r < 8) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    o.addr  = BASE + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
    r = int'($urandom_range(0, 99));
    if (r < 5)      o.addr = BASE + 32'h1000 + 32'($urandom_range(0, 255)) * 4;
    else if (r < 8) o.addr = BASE - 32'd4;
    o.wdata = $urandom();
    o.chk_model = 1'b1; o.exp_err = 1'b0; o.exp_rdata = '0;
    return o;
  endfunction

  // Pipelined master: address phase of op nxt overlaps data phase of op cur.
  task automatic run_ops(input int w);
    int          cur, nxt, lows, n, ws, exp_lows;
    logic        active, e;
    logic [31:0] exp_d;
    ws = (w == 1) ? 2 : 0;
    n = ops.size(); cur = -1; nxt = 0; lows = 0;
    which = w;
    forever begin
      if (nxt < n) begin
        m_sel = 1'b1; m_trans = ops[nxt].trans; m_wr = ops[nxt].wr;
        m_size = ops[nxt].size; m_addr = ops[nxt].addr;
      end else begin
        m_sel = 1'b0; m_trans = 2'b00;
      end
      if (cur >= 0) m_wdata = ops[cur].wdata;
      @(negedge clk);
      active = (cur >= 0) && ops[cur].trans[1];
      e = active && (ops[cur].chk_model ? model_err(ops[cur]) : ops[cur].exp_err);
      if (!s_rdy) begin
        lows++;
        chk($sformatf("wait_resp w%0d op%0d", w, cur), 32'(s_resp), 32'(e));
        if (lows > 16) begin
          checks++; errors++;
          $display("FAIL timeout w%0d op%0d: HREADYOUT low %0d cycles, limit 16", w, cur, lows);
          break;
        end
      end else begin
        if (cur >= 0) begin
          exp_lows = !active ? 0 : (e ? 1 : ws);
          chk($sformatf("waits w%0d op%0d", w, cur), 32'(lows), 32'(exp_lows));
          chk($sformatf("resp w%0d op%0d", w, cur), 32'(s_resp), 32'(e));
          if (active && !e && !ops[cur].wr) begin
            exp_d = ops[cur].chk_model ? model_rd(w, ops[cur].addr) : ops[cur].exp_rdata;
            chk($sformatf("rdata w%0d op%0d", w, cur), s_rdata, exp_d);
            last_rd[w] = exp_d;
          end else begin
            chk($sformatf("hold w%0d op%0d", w, cur), s_rdata, last_rd[w]);
          end
          if (active && !e && ops[cur].wr) model_wr(w, ops[cur]);
        end
        lows = 0;
        if (nxt >= n) break;
        cur = nxt;
        nxt++;
      end
      @(posedge clk); #1;
    end
    m_sel = 1'b0; m_trans = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    m_sel = 1'b0; m_trans = 2'b00; m_wr = 1'b0; m_size = 3'd0;
    m_addr = '0; m_wdata = '0; which = 0;
    last_rd[0] = '0; last_rd[1] = '0;

    // {trans, write, size, offset, wdata, exp_err, exp_rdata, use_model}
    tbl.push_back(mk(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'd0, 32'h13, 32'hAA556677, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hAA223344, 1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b11, 1'b1, 3'd1, 32'h12, 32'hBEEF1234, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hBEEF3344, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'h02, 32'h0,        1'b1, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'h1000, 32'h0,      1'b1, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0));
    tbl.push_back(mk(2'b00, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b01, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hBEEF3344, 1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,  1'b1, 32'h0,        1'b0));
    tbl.push_back(mk(2'b10, 1'b1, 3'd2, 32'hFFC, 32'hCAFE0001, 1'b0, 32'h0,       1'b0));
    tbl.push_back(mk(2'b10, 1'b0, 3'd2, 32'hFFC, 32'h0,       1'b0, 32'hCAFE0001, 1'b0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy0", 32'(bus0.HREADYOUT), 32'd1);
    chk("reset_resp0", 32'(bus0.HRESP), 32'd0);
    chk("reset_rdata0", bus0.HRDATA, 32'd0);
    chk("reset_rdy2", 32'(bus2.HREADYOUT), 32'd1);
    chk("reset_resp2", 32'(bus2.HRESP), 32'd0);
    chk("reset_rdata2", bus2.HRDATA, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < 2; w++) begin
      ops.delete();
      for (int i = 0; i < 16; i++)
        ops.push_back(mk(2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom(), 1'b0, 32'h0, 1'b1));
      run_ops(w);
      ops = tbl;
      run_ops(w);
      ops.delete();
      for (int i = 0; i < 150; i++) ops.push_back(rand_op());
      run_ops(w);
    end

`ifdef AHB_SUB_WRITE_PROTECT_EN
    wp = 1'b1;
    ops.delete();
    ops.push_back(mk(2'b10, 1'b1, 3'd2, 32'h0, 32'h5, 1'b1, 32'h0, 1'b0));
    ops.push_back(mk(2'b10, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1));
    run_ops(0);
    run_ops(1);
    wp = 1'b0;
`endif

    // Reset lands while the two-wait-state instance is stalling a write.
    which = 1;
    m_sel = 1'b1; m_trans = 2'b10; m_wr = 1'b1; m_size = 3'd2; m_addr = BASE + 32'h20;
    @(posedge clk); #1;
    m_sel = 1'b0; m_trans = 2'b00; m_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("rst_pre_wait", 32'(s_rdy), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_rdy", 32'(s_rdy), 32'd1);
    chk("rst_resp", 32'(s_resp), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ops.delete();
    ops.push_back(mk(2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1));
    run_ops(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
